// File: rtl/sdram_port_arbiter_if.sv
// Client-side and controller-side buses of sdram_port_arbiter; port i owns slice i of every p_* bus.
// master = arbiter view, slave = client/controller environment view.
interface sdram_port_arbiter_if #(
  parameter int NUM_PORTS    = 4,
  parameter int ADDR_WIDTH   = 25,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 8
);
  logic [NUM_PORTS*ADDR_WIDTH-1:0]              p_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0]              p_data;
  logic [NUM_PORTS*2-1:0]                       p_byte_en;
  logic [NUM_PORTS-1:0]                         p_wr_req;
  logic [NUM_PORTS-1:0]                         p_rd_req;
  logic [NUM_PORTS*DATA_WIDTH*BURST_LENGTH-1:0] p_q;
  logic [NUM_PORTS-1:0]                         p_ready;
  logic [NUM_PORTS-1:0]                         p_busy;
  logic                                         ctrl_init_complete;
  logic [ADDR_WIDTH-1:0]                        ctrl_addr;
  logic [DATA_WIDTH-1:0]                        ctrl_data;
  logic [1:0]                                   ctrl_byte_en;
  logic                                         ctrl_wr_req;
  logic                                         ctrl_rd_req;
  logic [DATA_WIDTH*BURST_LENGTH-1:0]           ctrl_q;
  logic                                         ctrl_ready;
  logic                                         timeout_err;

  modport master (
    input  p_addr, p_data, p_byte_en, p_wr_req, p_rd_req,
    output p_q, p_ready, p_busy,
    input  ctrl_init_complete,
    output ctrl_addr, ctrl_data, ctrl_byte_en, ctrl_wr_req, ctrl_rd_req,
    input  ctrl_q, ctrl_ready,
    output timeout_err
  );

  modport slave (
    output p_addr, p_data, p_byte_en, p_wr_req, p_rd_req,
    input  p_q, p_ready, p_busy,
    output ctrl_init_complete,
    input  ctrl_addr, ctrl_data, ctrl_byte_en, ctrl_wr_req, ctrl_rd_req,
    output ctrl_q, ctrl_ready,
    input  timeout_err
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// N-port request latch and arbiter feeding the sdram controller p0 port; ctrl_*_req rises 2 edges after capture.
// Busy ports drop new requests; optional WAIT watchdog enabled by `define SDRAM_ARB_TIMEOUT_EN.
module sdram_port_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int ADDR_WIDTH     = 25,
  parameter int DATA_WIDTH     = 16,
  parameter int BURST_LENGTH   = 8,
  parameter int ROUND_ROBIN    = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  reset_n,
  sdram_port_arbiter_if.master bus
);

  localparam int QW = DATA_WIDTH * BURST_LENGTH;
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("sdram_port_arbiter: parameter out of range");
  end

  logic [1:0]                           state_q, state_d;
  logic [PW-1:0]                        grant_q, grant_d;
  logic [PW-1:0]                        ptr_q, ptr_d;
  logic                                 op_wr_q, op_wr_d;
  logic [NUM_PORTS-1:0]                 pending_q, pending_d;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [NUM_PORTS-1:0][1:0]            lat_be_q, lat_be_d;
  logic [NUM_PORTS-1:0]                 lat_wr_q, lat_wr_d;
  logic [ADDR_WIDTH-1:0]                ctrl_addr_q, ctrl_addr_d;
  logic [DATA_WIDTH-1:0]                ctrl_data_q, ctrl_data_d;
  logic [1:0]                           ctrl_be_q, ctrl_be_d;
  logic                                 ctrl_wr_q, ctrl_wr_d;
  logic                                 ctrl_rd_q, ctrl_rd_d;
  logic [NUM_PORTS-1:0][QW-1:0]         p_q_q, p_q_d;
  logic [NUM_PORTS-1:0]                 p_ready_q, p_ready_d;

  logic          sel_vld;
  logic [PW-1:0] sel_idx;
  logic [PW-1:0] arb_base;
  logic          done;

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_err_q, tmo_err_d;
`endif

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  // Fixed priority is round-robin with the scan always starting at port 0.
  assign arb_base = (ROUND_ROBIN != 0) ? ptr_q : '0;

  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (pending_q[wrap_add(arb_base, k)]) begin
        sel_vld = 1'b1;
        sel_idx = wrap_add(arb_base, k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    op_wr_d     = op_wr_q;
    pending_d   = pending_q;
    lat_addr_d  = lat_addr_q;
    lat_data_d  = lat_data_q;
    lat_be_d    = lat_be_q;
    lat_wr_d    = lat_wr_q;
    ctrl_addr_d = ctrl_addr_q;
    ctrl_data_d = ctrl_data_q;
    ctrl_be_d   = ctrl_be_q;
    ctrl_wr_d   = 1'b0;
    ctrl_rd_d   = 1'b0;
    p_q_d       = p_q_q;
    p_ready_d   = '0;
    done        = 1'b0;
`ifdef SDRAM_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    tmo_err_d   = tmo_err_q;
`endif

    // Requests on a busy port are dropped; write wins a wr/rd collision.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!pending_q[i] && (bus.p_wr_req[i] || bus.p_rd_req[i])) begin
        pending_d[i]  = 1'b1;
        lat_addr_d[i] = bus.p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        lat_data_d[i] = bus.p_data[i*DATA_WIDTH +: DATA_WIDTH];
        lat_be_d[i]   = bus.p_byte_en[i*2 +: 2];
        lat_wr_d[i]   = bus.p_wr_req[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.ctrl_init_complete && sel_vld) begin
          grant_d     = sel_idx;
          ctrl_addr_d = lat_addr_q[sel_idx];
          ctrl_data_d = lat_data_q[sel_idx];
          ctrl_be_d   = lat_be_q[sel_idx];
          op_wr_d     = lat_wr_q[sel_idx];
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        ctrl_wr_d = op_wr_q;
        ctrl_rd_d = !op_wr_q;
        state_d   = S_WAIT;
`ifdef SDRAM_ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (bus.ctrl_ready) begin
          if (!op_wr_q) p_q_d[grant_q] = bus.ctrl_q;
          done = 1'b1;
        end
`ifdef SDRAM_ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tmo_err_d = 1'b1;
          done      = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        // A timed-out port also yields its turn so the rest keep moving.
        if (done) begin
          p_ready_d[grant_q] = 1'b1;
          pending_d[grant_q] = 1'b0;
          if (ROUND_ROBIN != 0) ptr_d = wrap_add(grant_q, 1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      op_wr_q     <= 1'b0;
      pending_q   <= '0;
      lat_addr_q  <= '0;
      lat_data_q  <= '0;
      lat_be_q    <= '0;
      lat_wr_q    <= '0;
      ctrl_addr_q <= '0;
      ctrl_data_q <= '0;
      ctrl_be_q   <= '0;
      ctrl_wr_q   <= 1'b0;
      ctrl_rd_q   <= 1'b0;
      p_q_q       <= '0;
      p_ready_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      op_wr_q     <= op_wr_d;
      pending_q   <= pending_d;
      lat_addr_q  <= lat_addr_d;
      lat_data_q  <= lat_data_d;
      lat_be_q    <= lat_be_d;
      lat_wr_q    <= lat_wr_d;
      ctrl_addr_q <= ctrl_addr_d;
      ctrl_data_q <= ctrl_data_d;
      ctrl_be_q   <= ctrl_be_d;
      ctrl_wr_q   <= ctrl_wr_d;
      ctrl_rd_q   <= ctrl_rd_d;
      p_q_q       <= p_q_d;
      p_ready_q   <= p_ready_d;
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign bus.timeout_err = tmo_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.p_q          = p_q_q;
  assign bus.p_ready      = p_ready_q;
  assign bus.p_busy       = pending_q;
  assign bus.ctrl_addr    = ctrl_addr_q;
  assign bus.ctrl_data    = ctrl_data_q;
  assign bus.ctrl_byte_en = ctrl_be_q;
  assign bus.ctrl_wr_req  = ctrl_wr_q;
  assign bus.ctrl_rd_req  = ctrl_rd_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench: a round-robin arbiter for the main scenarios plus a fixed-priority one for ordering.
// A small controller model answers each issue 3 cycles later with ctrl_ready.
module tb_sdram_port_arbiter;
  localparam int NP  = 4;
  localparam int AW  = 25;
  localparam int DW  = 16;
  localparam int BL  = 8;
  localparam int QW  = DW * BL;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)) bus_rr ();
  sdram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL)) bus_fp ();

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL),
                       .ROUND_ROBIN(1), .TIMEOUT_CYCLES(TMO))
    dut_rr (.clk(clk), .reset_n(reset_n), .bus(bus_rr.master));

  sdram_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LENGTH(BL),
                       .ROUND_ROBIN(0), .TIMEOUT_CYCLES(TMO))
    dut_fp (.clk(clk), .reset_n(reset_n), .bus(bus_fp.master));

  int n_tests = 0;
  int n_fail  = 0;

  logic          resp_en = 1'b1;
  logic [QW-1:0] resp_dat = '0;
  int            resp_cnt = 0;
  int            fp_cnt = 0;
  logic [AW-1:0] iss_addr[$];
  logic [DW-1:0] iss_data[$];
  logic [1:0]    iss_be[$];
  logic          iss_wr[$];
  logic          iss_rd[$];
  logic [AW-1:0] fp_addr[$];
  int            rdy_cnt[NP] = '{default: 0};

  int base, r0, r1, r2, wi;
  logic [QW-1:0] exp_q;

  // Controller model for the round-robin instance: log every issue cycle, answer after 3 cycles.
  always @(negedge clk) begin
    bus_rr.ctrl_ready = 1'b0;
    bus_rr.ctrl_q     = resp_dat;
    if (!reset_n) begin
      resp_cnt = 0;
    end else if (bus_rr.ctrl_wr_req || bus_rr.ctrl_rd_req) begin
      iss_addr.push_back(bus_rr.ctrl_addr);
      iss_data.push_back(bus_rr.ctrl_data);
      iss_be.push_back(bus_rr.ctrl_byte_en);
      iss_wr.push_back(bus_rr.ctrl_wr_req);
      iss_rd.push_back(bus_rr.ctrl_rd_req);
      if (resp_en) resp_cnt = 3;
    end else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) bus_rr.ctrl_ready = 1'b1;
    end
    for (int p = 0; p < NP; p++) if (bus_rr.p_ready[p]) rdy_cnt[p]++;
  end

  always @(negedge clk) begin
    bus_fp.ctrl_ready = 1'b0;
    bus_fp.ctrl_q     = '0;
    if (!reset_n) begin
      fp_cnt = 0;
    end else if (bus_fp.ctrl_wr_req || bus_fp.ctrl_rd_req) begin
      fp_addr.push_back(bus_fp.ctrl_addr);
      fp_cnt = 3;
    end else if (fp_cnt > 0) begin
      fp_cnt--;
      if (fp_cnt == 0) bus_fp.ctrl_ready = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    bus_rr.p_addr[p*AW +: AW]  = a;
    bus_rr.p_data[p*DW +: DW]  = d;
    bus_rr.p_byte_en[p*2 +: 2] = be;
  endtask

  task automatic pulse(input logic [NP-1:0] wr, input logic [NP-1:0] rd);
    bus_rr.p_wr_req = wr;
    bus_rr.p_rd_req = rd;
    @(negedge clk);
    bus_rr.p_wr_req = '0;
    bus_rr.p_rd_req = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus_rr.p_busy != '0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, QW'(bus_rr.p_busy), QW'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_ready"}, QW'(bus_rr.p_ready), QW'(0));
    check({tag, "_p_busy"}, QW'(bus_rr.p_busy), QW'(0));
    check({tag, "_wr_req"}, QW'(bus_rr.ctrl_wr_req), QW'(0));
    check({tag, "_rd_req"}, QW'(bus_rr.ctrl_rd_req), QW'(0));
    check({tag, "_addr"}, QW'(bus_rr.ctrl_addr), QW'(0));
    check({tag, "_data"}, QW'(bus_rr.ctrl_data), QW'(0));
    check({tag, "_be"}, QW'(bus_rr.ctrl_byte_en), QW'(0));
    check({tag, "_tmo"}, QW'(bus_rr.timeout_err), QW'(0));
    for (int p = 0; p < NP; p++) check({tag, "_p_q"}, bus_rr.p_q[p*QW +: QW], QW'(0));
  endtask

  initial begin
    bus_rr.p_addr = '0; bus_rr.p_data = '0; bus_rr.p_byte_en = '0;
    bus_rr.p_wr_req = '0; bus_rr.p_rd_req = '0; bus_rr.ctrl_init_complete = 1'b0;
    bus_fp.p_addr = '0; bus_fp.p_data = '0; bus_fp.p_byte_en = '0;
    bus_fp.p_wr_req = '0; bus_fp.p_rd_req = '0; bus_fp.ctrl_init_complete = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Write before init completes: held pending, issued once init rises.
    set_port(0, 25'h0322020, 16'h1234, 2'b11);
    base = iss_addr.size(); r0 = rdy_cnt[0];
    pulse(4'b0001, 4'b0000);
    repeat (10) @(negedge clk);
    check("preinit_issues", QW'(iss_addr.size() - base), QW'(0));
    check("preinit_busy", QW'(bus_rr.p_busy[0]), QW'(1));
    bus_rr.ctrl_init_complete = 1'b1;
    wait_idle("init");
    check("init_issues", QW'(iss_addr.size() - base), QW'(1));
    check("init_addr", QW'(iss_addr[base]), QW'(25'h0322020));
    check("init_data", QW'(iss_data[base]), QW'(16'h1234));
    check("init_be", QW'(iss_be[base]), QW'(3));
    check("init_wr", QW'(iss_wr[base]), QW'(1));
    check("init_ready", QW'(rdy_cnt[0] - r0), QW'(1));

    // Capture-to-issue latency with the arbiter idle.
    set_port(1, 25'h0000111, 16'hBEEF, 2'b01);
    pulse(4'b0010, 4'b0000);
    check("lat_e0", QW'(bus_rr.ctrl_wr_req), QW'(0));
    @(negedge clk);
    check("lat_e1", QW'(bus_rr.ctrl_wr_req), QW'(0));
    @(negedge clk);
    check("lat_e2", QW'(bus_rr.ctrl_wr_req), QW'(1));
    check("lat_be", QW'(bus_rr.ctrl_byte_en), QW'(1));
    wait_idle("lat");

    // Read burst returns to port 2 only; a later write leaves it untouched.
    exp_q = 128'h3210_7654_BA98_FEDC_DEF0_9ABC_5678_1234;
    resp_dat = exp_q;
    set_port(2, 25'h0322020, 16'h0000, 2'b11);
    r2 = rdy_cnt[2];
    pulse(4'b0000, 4'b0100);
    wait_idle("rd");
    check("rd_q2", bus_rr.p_q[2*QW +: QW], exp_q);
    check("rd_q0", bus_rr.p_q[0*QW +: QW], QW'(0));
    check("rd_q1", bus_rr.p_q[1*QW +: QW], QW'(0));
    check("rd_q3", bus_rr.p_q[3*QW +: QW], QW'(0));
    check("rd_ready", QW'(rdy_cnt[2] - r2), QW'(1));
    check("rd_op", QW'(iss_rd[iss_rd.size() - 1]), QW'(1));
    resp_dat = '1;
    pulse(4'b0100, 4'b0000);
    wait_idle("wrkeep");
    check("wr_keeps_q2", bus_rr.p_q[2*QW +: QW], exp_q);

    // Round-robin from a fresh pointer; port 0 re-requests while port 1 is served.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_port(0, 25'h100, 16'h0001, 2'b11);
    set_port(1, 25'h101, 16'h0002, 2'b11);
    set_port(3, 25'h103, 16'h0003, 2'b11);
    base = iss_addr.size();
    pulse(4'b1011, 4'b0000);
    wi = 0;
    while (iss_addr.size() < base + 2 && wi < 100) begin
      @(negedge clk);
      wi++;
    end
    set_port(0, 25'h200, 16'h0004, 2'b11);
    pulse(4'b0001, 4'b0000);
    wait_idle("rr");
    check("rr_count", QW'(iss_addr.size() - base), QW'(4));
    check("rr_1st", QW'(iss_addr[base]), QW'(25'h100));
    check("rr_2nd", QW'(iss_addr[base + 1]), QW'(25'h101));
    check("rr_3rd", QW'(iss_addr[base + 2]), QW'(25'h103));
    check("rr_4th", QW'(iss_addr[base + 3]), QW'(25'h200));

    // Second request on a busy port is dropped.
    set_port(0, 25'h300, 16'h0A0A, 2'b11);
    base = iss_addr.size();
    pulse(4'b0001, 4'b0000);
    set_port(0, 25'h301, 16'h0B0B, 2'b11);
    pulse(4'b0001, 4'b0000);
    wait_idle("drop");
    check("drop_count", QW'(iss_addr.size() - base), QW'(1));
    check("drop_addr", QW'(iss_addr[base]), QW'(25'h300));
    check("drop_data", QW'(iss_data[base]), QW'(16'h0A0A));

    // Simultaneous write and read on one port: the write wins.
    set_port(1, 25'h310, 16'h5555, 2'b10);
    base = iss_addr.size();
    pulse(4'b0010, 4'b0010);
    wait_idle("coll");
    check("coll_count", QW'(iss_addr.size() - base), QW'(1));
    check("coll_wr", QW'(iss_wr[base]), QW'(1));
    check("coll_rd", QW'(iss_rd[base]), QW'(0));

    // Reset during WAIT abandons the request without a ready pulse.
    resp_en = 1'b0;
    set_port(2, 25'h320, 16'h0000, 2'b11);
    r2 = rdy_cnt[2];
    base = iss_addr.size();
    pulse(4'b0000, 4'b0100);
    wi = 0;
    while (iss_addr.size() == base && wi < 50) begin
      @(negedge clk);
      wi++;
    end
    repeat (2) @(negedge clk);
    check("midrst_busy_before", QW'(bus_rr.p_busy[2]), QW'(1));
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst_no_ready", QW'(rdy_cnt[2] - r2), QW'(0));
    check("midrst_no_reissue", QW'(iss_addr.size() - base), QW'(1));
    resp_en = 1'b1;

`ifdef SDRAM_ARB_TIMEOUT_EN
    // Watchdog: port 1 is never answered, port 2 is served afterwards.
    resp_en = 1'b0;
    set_port(1, 25'h400, 16'h1111, 2'b11);
    set_port(2, 25'h401, 16'h2222, 2'b11);
    r2 = rdy_cnt[2];
    base = iss_addr.size();
    pulse(4'b0110, 4'b0000);
    wi = 0;
    while (!bus_rr.ctrl_wr_req && wi < 50) begin
      @(negedge clk);
      wi++;
    end
    check("tmo_issue_addr", QW'(bus_rr.ctrl_addr), QW'(25'h400));
    wi = 0;
    while (!bus_rr.timeout_err && wi < 100) begin
      @(negedge clk);
      wi++;
    end
    check("tmo_delay", QW'(wi), QW'(TMO));
    check("tmo_ready1", QW'(bus_rr.p_ready[1]), QW'(1));
    resp_en = 1'b1;
    wait_idle("tmo");
    check("tmo_next_addr", QW'(iss_addr[base + 1]), QW'(25'h401));
    check("tmo_ready2", QW'(rdy_cnt[2] - r2), QW'(1));
    check("tmo_sticky", QW'(bus_rr.timeout_err), QW'(1));
`endif

    // Fixed priority: ports 3 and 1 pending, port 1 goes first.
    base = fp_addr.size();
    bus_fp.p_addr[3*AW +: AW] = 25'h503;
    bus_fp.p_addr[1*AW +: AW] = 25'h501;
    bus_fp.p_wr_req = 4'b1010;
    @(negedge clk);
    bus_fp.p_wr_req = '0;
    repeat (3) @(negedge clk);
    bus_fp.ctrl_init_complete = 1'b1;
    wi = 0;
    while (fp_addr.size() < base + 2 && wi < 200) begin
      @(negedge clk);
      wi++;
    end
    check("fp_count", QW'(fp_addr.size() - base), QW'(2));
    check("fp_first", QW'(fp_addr[base]), QW'(25'h501));
    check("fp_second", QW'(fp_addr[base + 1]), QW'(25'h503));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Parametrised N-port front end for the single-port SDRAM controller (`sdram`).
- Latches pulsed per-port read/write requests, arbitrates between ports and issues one request at a time on the controller's p0 interface.
- Routes each completion (ready pulse, burst read data) back to the port that made the request.
- Sits between client cores and `sdram`; generalises the current one-client arrangement to NUM_PORTS clients with a selectable priority mode.

Parameters:
- NUM_PORTS, 4: number of client ports (2..8).
- ADDR_WIDTH, 25: word address width.
- DATA_WIDTH, 16: write data width.
- BURST_LENGTH, 8: read burst words; read data width = DATA_WIDTH*BURST_LENGTH.
- ROUND_ROBIN, 1: 1 = round-robin arbitration; 0 = fixed priority, port 0 highest.
- TIMEOUT_CYCLES, 1024: watchdog limit, used only with SDRAM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- p_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice i.
- p_data  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- p_byte_en  in  NUM_PORTS*2  per-port byte enables.
- p_wr_req  in  NUM_PORTS  write request pulse.
- p_rd_req  in  NUM_PORTS  read request pulse.
- p_q  out  NUM_PORTS*DATA_WIDTH*BURST_LENGTH  per-port last read burst.
- p_ready  out  NUM_PORTS  one-cycle completion pulse.
- p_busy  out  NUM_PORTS  port has a pending or in-flight request.
- ctrl_init_complete  in  1  controller initialisation done.
- ctrl_addr  out  ADDR_WIDTH  controller address.
- ctrl_data  out  DATA_WIDTH  controller write data.
- ctrl_byte_en  out  2  controller byte enables.
- ctrl_wr_req  out  1  controller write request.
- ctrl_rd_req  out  1  controller read request.
- ctrl_q  in  DATA_WIDTH*BURST_LENGTH  controller read data.
- ctrl_ready  in  1  controller completion pulse.
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Reset:
  - All outputs 0; p_q cleared.
  - Pending flags, latched request fields and the round-robin pointer are cleared.
  - FSM enters IDLE.
- Request capture:
  - At a clock edge where port i is not busy and p_wr_req[i] or p_rd_req[i] is high, latch addr, data, byte_en and op, then set pending[i].
  - If wr and rd are both high in the same cycle, the write wins.
  - A request made while the port is busy is ignored (dropped); clients must wait for p_busy low.
  - p_busy[i] = pending[i], registered.
- FSM states:
  - IDLE: if ctrl_init_complete and any port is pending, select a grant and go to ISSUE. No issue is made before init completes; requests stay pending.
  - ISSUE: drive ctrl_addr/data/byte_en from the granted port's latch; assert ctrl_wr_req or ctrl_rd_req for exactly one cycle; go to WAIT.
  - WAIT: hold the ctrl_* fields stable. On ctrl_ready:
    - if the op is a read, copy ctrl_q into p_q slice of grant;
    - pulse p_ready[grant] for 1 cycle;
    - clear pending[grant];
    - if ROUND_ROBIN, set pointer = grant+1 (modulo NUM_PORTS);
    - go to IDLE.
- Arbitration:
  - Fixed mode: lowest-index pending port wins.
  - RR mode: first pending port at or after the pointer, wrapping past NUM_PORTS-1 to 0.
- Latency: with the arbiter idle, ctrl_*_req is asserted in the cycle following the second edge after the sampling edge.
- Simultaneous events:
  - A completion for port j and a new request on port k≠j in the same cycle: both take effect.
  - A new request on port j in its own completion cycle is ignored, because p_busy is still high.
- p_q holds its value until the next read completes on the same port. Write completions leave p_q unchanged.
- ctrl_ready seen outside WAIT is ignored.
- reset_n asserted mid-operation: immediate return to the reset state. The in-flight request is abandoned with no p_ready pulse.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles. If TIMEOUT_CYCLES elapse without ctrl_ready, set timeout_err (sticky until reset), pulse p_ready[grant], clear its pending flag and return to IDLE.
  - p_q is not updated on a timeout.
- Undefined: no counter; timeout_err tied 0; WAIT waits indefinitely.

Test Plan:
- Requests before ctrl_init_complete: p0 write to addr 0x0322020, data 0x1234 -> no ctrl_wr_req until init completes. Then exactly one ctrl_wr_req pulse with ctrl_addr=0x0322020, ctrl_data=0x1234, byte_en=3, followed by p_ready[0].
- Read return: port 2 reads 0x0322020; controller returns 128-bit burst 0x3210_7654_BA98_FEDC_DEF0_9ABC_5678_1234 -> p_q slice 2 equals that value; other slices unchanged; p_ready[2] pulses once.
- RR fairness (ROUND_ROBIN=1): ports 0, 1, 3 request in the same cycle -> issue order 0, 1, 3. A port-0 re-request during service of port 1 is served after port 3.
- Fixed priority (ROUND_ROBIN=0): ports 3 and 1 pending -> port 1 issued first.
- Busy drop and wr/rd collision: second request on busy port 0 -> exactly one issue. Simultaneous wr_req and rd_req -> ctrl_wr_req only.
- Timeout (macro on, TIMEOUT_CYCLES=16, ctrl_ready held low) -> timeout_err rises 16 cycles after issue, p_ready pulses, the FSM returns to IDLE and then serves the next pending port. Reset mid-WAIT -> all outputs 0, no p_ready pulse.
